// File: rtl/conv1_mul_arb.sv
// NUM_REQ-way arbiter sharing one unsigned 8x9 multiplier through a 2-stage valid/ready pipeline.
// Define CONV1_MUL_ARB_PRIO_EN to give requester 0 strict priority over a round-robin among the rest.
module conv1_mul_arb #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [8*NUM_REQ-1:0]     req_a,
   input  logic [9*NUM_REQ-1:0]     req_b,
   input  logic [TAG_W*NUM_REQ-1:0] req_tag,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [15:0]              res_data,
   output logic [ID_W-1:0]          res_id,
   output logic [TAG_W-1:0]         res_tag,
   output logic                     busy
);

   logic               s1_valid_q, s1_valid_d;
   logic [7:0]         s1_a_q, s1_a_d;
   logic [8:0]         s1_b_q, s1_b_d;
   logic [ID_W-1:0]    s1_id_q, s1_id_d;
   logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
   logic               res_valid_q, res_valid_d;
   logic [15:0]        res_data_q, res_data_d;
   logic [ID_W-1:0]    res_id_q, res_id_d;
   logic [TAG_W-1:0]   res_tag_q, res_tag_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;

   logic               s2_en_s, s1_en_s, found_s, xfer_s;
   logic [ID_W-1:0]    grant_idx_s;
   logic [NUM_REQ-1:0] grant_oh_s;
   logic [7:0]         sel_a_s;
   logic [8:0]         sel_b_s;
   logic [TAG_W-1:0]   sel_tag_s;
   logic [15:0]        prod_s;

   assign s2_en_s = !res_valid_q | res_ready;
   assign s1_en_s = !s1_valid_q | s2_en_s;

   // Arbiter: find the first valid requester after last_grant_q.
   always_comb begin
      int cand;
      cand        = 0;
      found_s     = 1'b0;
      grant_idx_s = '0;
`ifdef CONV1_MUL_ARB_PRIO_EN
      if (req_valid[0]) begin
         found_s     = 1'b1;
         grant_idx_s = '0;
      end else begin
         // rotation covers indices 1..NUM_REQ-1 only
         for (int off = 1; off < NUM_REQ; off++) begin
            cand = int'(last_grant_q) + off;
            cand = (cand > NUM_REQ - 1) ? cand - (NUM_REQ - 1) : cand;
            if (!found_s && req_valid[ID_W'(cand)]) begin
               found_s     = 1'b1;
               grant_idx_s = ID_W'(cand);
            end else begin
               found_s     = found_s;
            end
         end
      end
`else
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(last_grant_q) + off) % NUM_REQ;
         if (!found_s && req_valid[ID_W'(cand)]) begin
            found_s     = 1'b1;
            grant_idx_s = ID_W'(cand);
         end else begin
            found_s     = found_s;
         end
      end
`endif
   end

   assign grant_oh_s = {{(NUM_REQ-1){1'b0}}, found_s} << grant_idx_s;
   assign req_ready  = grant_oh_s & {NUM_REQ{s1_en_s & ap_rst_n}};
   assign xfer_s     = found_s & s1_en_s & ap_rst_n;

   // Operand mux driven by the one-hot grant.
   always_comb begin
      sel_a_s   = '0;
      sel_b_s   = '0;
      sel_tag_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_a_s   |= req_a[8*i +: 8]         & {8{grant_oh_s[i]}};
         sel_b_s   |= req_b[9*i +: 9]         & {9{grant_oh_s[i]}};
         sel_tag_s |= req_tag[TAG_W*i +: TAG_W] & {TAG_W{grant_oh_s[i]}};
      end
   end

   // 16-bit operands keep exactly the low 16 bits of the 17-bit product.
   assign prod_s = {8'h00, s1_a_q} * {7'h00, s1_b_q};

   // Next-state logic for both pipeline stages and the round-robin pointer.
   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_id_d      = s1_id_q;
      s1_tag_d     = s1_tag_q;
      res_valid_d  = res_valid_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      res_tag_d    = res_tag_q;
      if (s1_en_s) begin
         s1_valid_d = xfer_s;
         s1_a_d     = sel_a_s;
         s1_b_d     = sel_b_s;
         s1_id_d    = grant_idx_s;
         s1_tag_d   = sel_tag_s;
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (s2_en_s) begin
         res_valid_d = s1_valid_q;
         res_data_d  = s1_valid_q ? prod_s   : res_data_q;
         res_id_d    = s1_valid_q ? s1_id_q  : res_id_q;
         res_tag_d   = s1_valid_q ? s1_tag_q : res_tag_q;
      end else begin
         res_valid_d = res_valid_q;
      end
`ifdef CONV1_MUL_ARB_PRIO_EN
      last_grant_d = (xfer_s && (grant_idx_s != '0)) ? grant_idx_s : last_grant_q;
`else
      last_grant_d = xfer_s ? grant_idx_s : last_grant_q;
`endif
   end

   // State registers; reset points the pointer at the last index so requester 0 wins first.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= 8'h00;
         s1_b_q       <= 9'h000;
         s1_id_q      <= '0;
         s1_tag_q     <= '0;
         res_valid_q  <= 1'b0;
         res_data_q   <= 16'h0000;
         res_id_q     <= '0;
         res_tag_q    <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_id_q      <= s1_id_d;
         s1_tag_q     <= s1_tag_d;
         res_valid_q  <= res_valid_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
         res_tag_q    <= res_tag_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign res_tag   = res_tag_q;
   assign busy      = s1_valid_q | res_valid_q;

endmodule

// File: tb/tb_conv1_mul_arb.sv
// Self-checking bench for conv1_mul_arb: cycle model of occupancy/arbitration plus a result scoreboard.
module tb_conv1_mul_arb;
   localparam int N  = 4;
   localparam int TW = 4;

   logic            ap_clk = 1'b0;
   logic            ap_rst_n;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_a;
   logic [9*N-1:0]  req_b;
   logic [TW*N-1:0] req_tag;
   logic [N-1:0]    req_ready;
   logic            res_valid;
   logic            res_ready;
   logic [15:0]     res_data;
   logic [1:0]      res_id;
   logic [TW-1:0]   res_tag;
   logic            busy;

   conv1_mul_arb #(.NUM_REQ(N), .TAG_W(TW)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_a(req_a),
      .req_b(req_b), .req_tag(req_tag), .req_ready(req_ready), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .res_tag(res_tag),
      .busy(busy)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct packed {
      logic [1:0]    id;
      logic [TW-1:0] tag;
      logic [15:0]   data;
   } res_t;

   res_t sb[$];
   logic m_s1, m_s2;
   int   m_last;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant();
      int idx;
`ifdef CONV1_MUL_ARB_PRIO_EN
      if (req_valid[0]) return 0;
      for (int off = 1; off < N; off++) begin
         idx = m_last + off;
         if (idx > N - 1) idx = idx - (N - 1);
         if (req_valid[idx]) return idx;
      end
`else
      for (int off = 1; off <= N; off++) begin
         idx = (m_last + off) % N;
         if (req_valid[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   task automatic set_req(input int i, input int a, input int b, input int t);
      req_a[8*i +: 8]     = 8'(a);
      req_b[9*i +: 9]     = 9'(b);
      req_tag[TW*i +: TW] = TW'(t);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 511), $urandom_range(0, 15));
   endtask

   // One clock: check outputs against the model, score results, then advance the model.
   task automatic cycle();
      int           g;
      logic         s2_en, s1_en;
      logic [N-1:0] exp_rdy;
      logic [16:0]  p;
      res_t         e;
      #1;
      s2_en   = !m_s2 || res_ready;
      s1_en   = !m_s1 || s2_en;
      g       = s1_en ? model_grant() : -1;
      exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("res_valid", 32'(res_valid), 32'(m_s2));
      chk("busy", 32'(busy), 32'(m_s1 | m_s2));
      if (m_s2) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb[0];
            chk("res_data", 32'(res_data), 32'(e.data));
            chk("res_id", 32'(res_id), 32'(e.id));
            chk("res_tag", 32'(res_tag), 32'(e.tag));
            if (res_ready) void'(sb.pop_front());
         end
      end
      if (g >= 0) begin
         p      = {9'b0, req_a[g*8 +: 8]} * {8'b0, req_b[g*9 +: 9]};
         e.id   = 2'(g);
         e.tag  = req_tag[g*TW +: TW];
         e.data = p[15:0];
         sb.push_back(e);
      end
      @(posedge ap_clk);
      if (s2_en) m_s2 = m_s1;
      if (s1_en) m_s1 = (g >= 0);
`ifdef CONV1_MUL_ARB_PRIO_EN
      if (g > 0) m_last = g;
`else
      if (g >= 0) m_last = g;
`endif
      @(negedge ap_clk);
   endtask

   task automatic do_reset();
      #2 ap_rst_n = 1'b0;
      #1;
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_res_tag", 32'(res_tag), 32'd0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_last = N - 1;
      sb.delete();
   endtask

   initial begin
      int order [5] = '{0, 1, 2, 3, 0};
      int acc;
      ap_rst_n  = 1'b0;
      req_valid = 4'b1111;
      res_ready = 1'b1;
      req_a = '0; req_b = '0; req_tag = '0;
      @(negedge ap_clk);
      do_reset();
      req_valid = 4'b0000;
      cycle(); cycle();

      // 255 * 511 wraps to 16'hFD01, two edges after the transfer
      set_req(0, 255, 511, 3);
      req_valid = 4'b0001;
      cycle();
      req_valid = 4'b0000;
      cycle();
      #1;
      chk("fd01_data", 32'(res_data), 32'h0000FD01);
      chk("fd01_id", 32'(res_id), 32'd0);
      cycle(); cycle();

      // all requesters streaming, unobstructed output
      do_reset();
      rand_ops();
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
`ifndef CONV1_MUL_ARB_PRIO_EN
         #1;
         chk("rr_grant_order", 32'(req_ready), 32'd1 << order[k]);
`endif
         cycle();
         rand_ops();
      end
      req_valid = 4'b0000;
      cycle(); cycle(); cycle();

      // zero operand and small product with distinct tags
      set_req(0, 0, 300, 4'hA);
      req_valid = 4'b0001;
      cycle();
      set_req(0, 17, 3, 4'h5);
      cycle();
      req_valid = 4'b0000;
      #1;
      chk("zero_data", 32'(res_data), 32'd0);
      chk("zero_tag", 32'(res_tag), 32'hA);
      cycle();
      #1;
      chk("p51_data", 32'(res_data), 32'd51);
      chk("p51_tag", 32'(res_tag), 32'h5);
      cycle(); cycle();

      // output stalled for 5 cycles: only two entries fit
      acc = 0;
      res_ready = 1'b0;
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (req_ready != '0) acc++;
         cycle();
         rand_ops();
      end
      chk("stall_accepts", 32'(acc), 32'd2);
      req_valid = 4'b0000;
      res_ready = 1'b1;
      for (int k = 0; k < 4; k++) cycle();
      chk("stall_drained", 32'(sb.size()), 32'd0);

      // reset with both stages full, then requester 0 must win first
      res_ready = 1'b0;
      req_valid = 4'b1111;
      cycle(); cycle(); cycle();
      do_reset();
      res_ready = 1'b1;
      #1;
      chk("post_rst_grant", 32'(req_ready), 32'd1);
      for (int k = 0; k < 4; k++) cycle();
      req_valid = 4'b0000;
      cycle(); cycle(); cycle();

`ifdef CONV1_MUL_ARB_PRIO_EN
      do_reset();
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("prio_zero", 32'(req_ready), 32'd1);
         cycle();
      end
      req_valid = 4'b1110;
      for (int k = 1; k < 4; k++) begin
         #1;
         chk("prio_rest_order", 32'(req_ready), 32'd1 << k);
         cycle();
      end
      req_valid = 4'b0000;
      cycle(); cycle(); cycle();
`endif

      // random traffic and backpressure
      for (int k = 0; k < 300; k++) begin
         req_valid = N'($urandom_range(0, 15));
         res_ready = ($urandom_range(0, 9) < 7);
         rand_ops();
         cycle();
      end
      req_valid = 4'b0000;
      res_ready = 1'b1;
      for (int k = 0; k < 10 && sb.size() != 0; k++) cycle();
      chk("final_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/conv1_mul_arb.md
CONV1_MUL_ARB -- requirements
Module: conv1_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing the multiplier (2..8).
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the opaque per-request tag.
REQ-003 SHALL have port ap_clk  input  1  meaning the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  meaning a per-requester operand-valid flag.
REQ-006 SHALL have port req_a  input  8*NUM_REQ  meaning unsigned 8-bit operand A, with requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_b  input  9*NUM_REQ  meaning unsigned 9-bit operand B, with requester i at bits [9i+8:9i].
REQ-008 SHALL have port req_tag  input  TAG_W*NUM_REQ  meaning the per-requester tag, returned unchanged with the result.
REQ-009 SHALL have port req_ready  output  NUM_REQ  meaning a one-hot accept flag, asserted only for the granted requester.
REQ-010 SHALL have port res_valid  output  1  meaning the result is valid.
REQ-011 SHALL have port res_ready  input  1  meaning the consumer accepts the result.
REQ-012 SHALL have port res_data  output  16  meaning the product.
REQ-013 SHALL have port res_id  output  $clog2(NUM_REQ)  meaning the index of the originating requester.
REQ-014 SHALL have port res_tag  output  TAG_W  meaning the originating tag.
REQ-015 SHALL have port busy  output  1  meaning at least one pipeline stage holds a valid entry.

Function
REQ-016 SHALL use one shared unsigned 8x9 multiplier, zero-extending both operands, with res_data equal to the low 16 bits of the 17-bit product (wrap, no saturation).
REQ-017 SHALL be a 2-stage pipeline: S1 registers the granted operands, id and tag; S2 registers the product, id and tag, and drives the res_* ports.
REQ-018 SHALL define s2_en = !res_valid | res_ready and s1_en = !s1_valid | s2_en; S1 loads only when s1_en, and S2 loads only when s2_en.
REQ-019 SHALL make a transfer occur when req_valid[i] & req_ready[i]; req_ready SHALL be all zero when s1_en=0 or when no req_valid bit is set.
REQ-020 SHALL grant in round-robin order: the search starts at last_grant+1 modulo NUM_REQ, and last_grant updates only on a transfer.
REQ-021 SHALL set latency to 2: a transfer on edge k produces res_valid=1 after edge k+1 with an uncongested output, and throughput SHALL be 1 result per cycle.
REQ-022 SHALL hold res_valid, res_data, res_id and res_tag stable while res_valid=1 and res_ready=0, and SHALL stall S1 when both stages are full; no result SHALL be dropped or duplicated.
REQ-023 SHALL allow a result to drain and a new request to be accepted in the same cycle (simultaneous pop/push) without a bubble.
REQ-024 SHALL ensure a requester that deasserts req_valid without a transfer is never granted, and no ordering is promised across requesters.
REQ-025 SHALL ensure any requester holding req_valid=1 is granted within NUM_REQ transfers (starvation-free, round-robin mode only).
REQ-026 SHALL drive busy = s1_valid | res_valid.

Reset
REQ-027 SHALL, when ap_rst_n=0, asynchronously clear s1_valid, res_valid and busy, clear res_data, res_id and res_tag to 0, and set last_grant to NUM_REQ-1 so that requester 0 wins first.
REQ-028 SHALL discard in-flight entries on reset asserted mid-operation, keeping req_ready at 0 while in reset; the first grant after deassertion SHALL occur no earlier than the first rising edge with ap_rst_n=1.

Configuration
REQ-029 SHALL, with CONV1_MUL_ARB_PRIO_EN defined, make requester 0 strict highest priority: it wins whenever req_valid[0]=1, and the remaining requesters stay round-robin among themselves with their pointer advancing only on grants to indices 1..NUM_REQ-1.
REQ-030 SHALL, with CONV1_MUL_ARB_PRIO_EN undefined, apply pure round-robin per REQ-020 across all requesters, with REQ-025 holding.

Verification
REQ-031 SHALL cover: after reset, req_valid=4'b0001, a=255, b=511, res_ready=1 -> 2 cycles later res_valid=1, res_data=16'hFD01, res_id=0.
REQ-032 SHALL cover: req_valid=4'b1111 held, res_ready=1 -> grants in order 0,1,2,3,0, with res_id following the same order at 1 result per cycle.
REQ-033 SHALL cover: res_ready=0 for 5 cycles with streaming input -> exactly 2 accepts, then req_ready=0 and res_* stable; on release, all results delivered in order with none lost.
REQ-034 SHALL cover: ap_rst_n pulsed low with both stages full -> res_valid=0 and busy=0 immediately, and the next grant goes to requester 0.
REQ-035 SHALL cover: a=0, b=300 and a=17, b=3 with tags 4'hA and 4'h5 -> res_data=0 then 51, with res_tag=A then 5.
REQ-036 SHALL cover: with CONV1_MUL_ARB_PRIO_EN defined and req_valid=4'b1111 held -> requester 0 granted every cycle, and its release yields grants 1,2,3.
